// File: rtl/serial_subtractor.sv
// Bit-serial subtractor d = a - b - bin, one bit per clock, LSB first.
// Optional signed-overflow output ovf when SERIAL_SUBTRACTOR_OVF_EN is defined.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             busy,
  output logic             done
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  ,
  output logic             ovf
`endif
);

  // state | meaning
  // IDLE  | waiting for start, d/bout hold last result
  // RUN   | one bit processed per edge, WIDTH edges total
  // DONE  | single-cycle done pulse, start here chains straight into RUN
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             br;
  logic [CW-1:0]    cnt;

  logic ai, bi, diff, br_next;

  always_comb begin
    ai      = a_q[0];
    bi      = b_q[0];
    diff    = ai ^ bi ^ br;
    br_next = (~ai & bi) | (~(ai ^ bi) & br);
  end

  // The minuend register doubles as the result shifter: consumed bits leave
  // at the LSB while difference bits enter at the MSB.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      d     <= '0;
      bout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            br    <= bin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_q <= {diff, a_q[WIDTH-1:1]};
          b_q <= {1'b0, b_q[WIDTH-1:1]};
          br  <= br_next;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            d     <= {diff, a_q[WIDTH-1:1]};
            bout  <= br_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            // On the last bit ai/bi are the operand sign bits and diff is d's sign.
            ovf   <= (ai ^ bi) & (ai ^ diff);
`endif
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8): vector table plus
// hand-written sequences for mid-run start, mid-run reset and back-to-back ops.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n, start, bin;
  logic [W-1:0] a, b, d;
  logic         bout, busy, done;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic         ovf;
`endif

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .d     (d),
    .bout  (bout),
    .busy  (busy),
    .done  (done)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] d;
    logic         bout;
    logic         ovf;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  int n_cmp  = 0;
  int n_fail = 0;

  logic [W-1:0] prev_d;
  logic         prev_bout;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_result(input string tag, input vec_t v);
    chk({tag, " d"}, 32'(d), 32'(v.d));
    chk({tag, " bout"}, 32'(bout), 32'(v.bout));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    chk({tag, " ovf"}, 32'(ovf), 32'(v.ovf));
`endif
  endtask

  // Full operation; with disturb set, a competing start with new operands
  // is driven in RUN cycle 3 and must be ignored.
  task automatic run_op(input vec_t v, input bit disturb);
    @(negedge clk);
    a = v.a; b = v.b; bin = v.bin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = ~v.a; b = ~v.b; bin = ~v.bin;
    for (int k = 1; k <= W; k++) begin
      chk($sformatf("run busy k=%0d", k), 32'(busy), 32'd1);
      chk($sformatf("run done k=%0d", k), 32'(done), 32'd0);
      chk($sformatf("run hold d k=%0d", k), 32'(d), 32'(prev_d));
      chk($sformatf("run hold bout k=%0d", k), 32'(bout), 32'(prev_bout));
      if (disturb && k == 3) begin
        start = 1'b1; a = 8'hFF; b = 8'hFF; bin = 1'b0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("done pulse", 32'(done), 32'd1);
    chk("done busy", 32'(busy), 32'd0);
    chk_result($sformatf("result %02h-%02h-%0d", v.a, v.b, v.bin), v);
    @(negedge clk);
    chk("done width", 32'(done), 32'd0);
    chk("no restart", 32'(busy), 32'd0);
    chk("idle hold d", 32'(d), 32'(v.d));
    prev_d    = v.d;
    prev_bout = v.bout;
  endtask

  initial begin
    int done_cnt;
    int last_done;
    int n_done;
    int guard;

    //            a      b      bin   d      bout  ovf
    vecs[0] = '{8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[2] = '{8'h80, 8'h01, 1'b1, 8'h7E, 1'b0, 1'b1};
    vecs[3] = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[5] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[6] = '{8'h55, 8'hAA, 1'b0, 8'hAB, 1'b1, 1'b1};
    vecs[7] = '{8'hAA, 8'h55, 1'b1, 8'h54, 1'b0, 1'b1};
    vecs[8] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[9] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0};

    rst_n = 1'b0; start = 1'b1; a = 8'hA5; b = 8'h5A; bin = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset d", 32'(d), 32'd0);
    chk("reset bout", 32'(bout), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    start = 1'b0;
    rst_n = 1'b1;
    prev_d = '0;
    prev_bout = 1'b0;

    for (int i = 0; i < NV; i++) run_op(vecs[i], 1'b0);

    // competing start mid-run is ignored
    run_op(vecs[3], 1'b1);

    // reset during RUN cycle 4 aborts with no done
    @(negedge clk);
    a = vecs[0].a; b = vecs[0].b; bin = vecs[0].bin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre-abort busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort d", 32'(d), 32'd0);
    chk("abort bout", 32'(bout), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    done_cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("abort no done", 32'(done_cnt), 32'd0);
    prev_d = '0;
    prev_bout = 1'b0;

    // start held across DONE: back-to-back operations
    @(negedge clk);
    a = vecs[0].a; b = vecs[0].b; bin = vecs[0].bin; start = 1'b1;
    last_done = -1;
    n_done = 0;
    guard = 0;
    while (n_done < 3 && guard < 60) begin
      @(negedge clk);
      guard++;
      if (done) begin
        chk_result($sformatf("b2b op%0d", n_done), vecs[n_done]);
        if (last_done >= 0)
          chk($sformatf("b2b spacing op%0d", n_done), 32'(cyc - last_done), 32'(W + 1));
        last_done = cyc;
        n_done++;
        if (n_done < 3) begin
          a = vecs[n_done].a; b = vecs[n_done].b; bin = vecs[n_done].bin;
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    chk("b2b ops completed", 32'(n_done), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range 2..32.
REQ-002 The module SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit, reset that is synchronous and active-low.
REQ-004 The module SHALL have port start, input, 1 bit, a request to begin a subtraction.
REQ-005 The module SHALL have port a, input, WIDTH bits, the minuend.
REQ-006 The module SHALL have port b, input, WIDTH bits, the subtrahend.
REQ-007 The module SHALL have port bin, input, 1 bit, the borrow-in.
REQ-008 The module SHALL have port d, output, WIDTH bits, the difference a - b - bin modulo 2^WIDTH.
REQ-009 The module SHALL have port bout, output, 1 bit, the final borrow-out (1 when a < b + bin, unsigned).
REQ-010 The module SHALL have port busy, output, 1 bit, high while an operation is in progress.
REQ-011 The module SHALL have port done, output, 1 bit, a one-cycle pulse marking the result as valid.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 In IDLE or DONE with start=1 at an edge, the block SHALL capture a, b and bin, clear the bit counter and enter RUN.
REQ-014 In RUN, each edge SHALL process one bit, LSB first:
- diff = ai ^ bi ^ br;
- br_next = (~ai & bi) | (~(ai ^ bi) & br);
- diff is shifted into the MSB of the result register.
REQ-015 After WIDTH RUN edges the FSM SHALL enter DONE; the result SHALL then be aligned so that d[i] = diff of bit i, and bout = final br.
REQ-016 Latency: with start sampled at edge 0, done SHALL be high exactly in the cycle following edge WIDTH, i.e. WIDTH+1 edges after the request.
REQ-017 done SHALL be high only in DONE; DONE SHALL last one cycle and return to IDLE unless start=1, which goes to RUN.
REQ-018 busy SHALL equal 1 in RUN only.
REQ-019 start while busy=1 SHALL be ignored; captured operands SHALL NOT change, and input changes during RUN SHALL have no effect.
REQ-020 d and bout SHALL hold the last completed result through IDLE until the next operation reaches DONE.
REQ-021 During RUN, d and bout SHALL hold the previous completed result; partial values SHALL NOT be visible.

Reset
REQ-022 With rst_n=0 at an edge, the state SHALL become IDLE, and d, bout, busy, done, the counter, the borrow register and the operand registers SHALL all become 0.
REQ-023 Reset SHALL take priority over start and abort any RUN in progress; no done pulse SHALL follow an aborted operation.
REQ-024 The first start accepted after rst_n returns to 1 SHALL behave per REQ-013.

Configuration
REQ-025 With macro SERIAL_SUBTRACTOR_OVF_EN defined, the module SHALL add output port ovf (1 bit): signed two's-complement overflow = (a[MSB] ^ b[MSB]) & (a[MSB] ^ d[MSB]).
REQ-026 ovf SHALL be updated together with d, reset to 0 and held like d.
REQ-027 Without SERIAL_SUBTRACTOR_OVF_EN, port ovf and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (WIDTH=8)
REQ-028 a=0x35, b=0x12, bin=0, start pulse -> busy=1 for 8 cycles, then done=1 for one cycle with d=0x23 and bout=0.
REQ-029 a=0x00, b=0x01, bin=0 -> d=0xFF, bout=1; with OVF_EN, ovf=0.
REQ-030 a=0x80, b=0x01, bin=1 -> d=0x7E, bout=0; with OVF_EN, ovf=1.
REQ-031 Start at a=0x10, b=0x01, then at cycle 3 of RUN drive start=1 with a=0xFF, b=0xFF -> the result is 0x0F with done on schedule, and no second operation starts.
REQ-032 rst_n=0 at cycle 4 of RUN -> next cycle busy=0 and d=0; no done pulse for the next 10 cycles.
REQ-033 start held high across DONE -> back-to-back operations with done pulses exactly WIDTH+1 cycles apart, each producing the correct result.
